// File: rtl/axi_lite_led_ctrl.sv
// AXI4-Lite LED controller: direct pattern output or hardware blink with a programmable half-period.
// Define LED_CTRL_PWM_EN to add the DUTY register (0x10) and an 8-bit PWM brightness gate.
module axi_lite_led_ctrl #(
  parameter int          C_ADDR_WIDTH = 5,
  parameter int          NUM_LEDS     = 4,
  parameter logic [31:0] RESET_PERIOD = 32'd25000000
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [C_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [31:0]             s_axi_wdata,
  input  logic [3:0]              s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [C_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [31:0]             s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [NUM_LEDS-1:0]     led_o
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_DATA } r_state_t;

  w_state_t w_state, w_state_n;
  r_state_t r_state, r_state_n;

  logic [NUM_LEDS-1:0] led_data;
  logic                mode;
  logic [31:0]         period;
  logic [31:0]         blink_cnt;
  logic                phase;
  logic                pwm_gate;

  logic [2:0]  wr_idx, rd_idx;
  logic [31:0] strb_mask;
  logic [31:0] led_merged;
  logic [31:0] period_merged;
  logic        wr_fire, rd_fire;
  logic        wr_led, wr_mode, wr_period, wr_duty, wr_err;
  logic        wr_restart;
  logic [31:0] rd_value;
  logic        rd_err;
  logic [31:0] status_word;
  logic [NUM_LEDS-1:0] led_pattern;
  logic        unused_addr_bits;

  assign wr_idx = s_axi_awaddr[4:2];
  assign rd_idx = s_axi_araddr[4:2];
  assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  assign strb_mask = {{8{s_axi_wstrb[3]}}, {8{s_axi_wstrb[2]}},
                      {8{s_axi_wstrb[1]}}, {8{s_axi_wstrb[0]}}};
  assign led_merged    = merge_bytes(32'(led_data), s_axi_wdata, strb_mask);
  assign period_merged = merge_bytes(period, s_axi_wdata, strb_mask);

  // ---------------- write channel ----------------
  always_ff @(posedge ACLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (ARESET) w_state <= W_IDLE;
    else        w_state <= w_state_n;
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path leaves a latch behind.
    w_state_n     = w_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (s_axi_awvalid && s_axi_wvalid && !ARESET) begin
          s_axi_awready = 1'b1;
          s_axi_wready  = 1'b1;
          w_state_n     = W_RESP;
        end
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_state_n = W_IDLE;
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  assign wr_fire = s_axi_awready;

  always_comb begin
    wr_led    = 1'b0;
    wr_mode   = 1'b0;
    wr_period = 1'b0;
    wr_duty   = 1'b0;
    wr_err    = 1'b0;
    case (wr_idx)
      3'd0: wr_led    = 1'b1;
      3'd1: wr_mode   = 1'b1;
      3'd2: wr_period = 1'b1;
`ifdef LED_CTRL_PWM_EN
      3'd4: wr_duty   = 1'b1;
`endif
      default: wr_err = 1'b1;
    endcase
  end

  // A strobe-less write touches nothing, including the blink timebase.
  assign wr_restart = wr_fire && (wr_mode || wr_period) && (|s_axi_wstrb);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      led_data    <= '0;
      mode        <= 1'b0;
      period      <= RESET_PERIOD;
      s_axi_bresp <= RESP_OKAY;
    end else if (wr_fire) begin
      if (wr_led)                     led_data <= led_merged[NUM_LEDS-1:0];
      if (wr_mode && s_axi_wstrb[0])  mode     <= s_axi_wdata[0];
      if (wr_period)                  period   <= period_merged;
      s_axi_bresp <= wr_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // ---------------- blink timebase ----------------
  always_ff @(posedge ACLK) begin
    if (ARESET || wr_restart || period == 32'd0) begin
      blink_cnt <= 32'd0;
      phase     <= 1'b1;
    end else if (mode) begin
      if (blink_cnt == period - 32'd1) begin
        blink_cnt <= 32'd0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 32'd1;
      end
    end
  end

`ifdef LED_CTRL_PWM_EN
  logic [7:0] duty;
  logic [7:0] pwm_cnt;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      duty    <= 8'hFF;
      pwm_cnt <= 8'd0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (wr_fire && wr_duty && s_axi_wstrb[0]) duty <= s_axi_wdata[7:0];
    end
  end

  assign pwm_gate = (pwm_cnt < duty);
`else
  assign pwm_gate = 1'b1;
`endif

  // ---------------- LED output ----------------
  assign led_pattern = ((mode && !phase) ? '0 : led_data) & {NUM_LEDS{pwm_gate}};

  always_ff @(posedge ACLK) begin
    if (ARESET) led_o <= '0;
    else        led_o <= led_pattern;
  end

  // ---------------- read channel ----------------
  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= R_IDLE;
    else        r_state <= r_state_n;
  end

  always_comb begin
    r_state_n     = r_state;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_axi_arready = !ARESET;
        if (s_axi_arvalid && !ARESET) r_state_n = R_DATA;
      end
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) r_state_n = R_IDLE;
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  assign rd_fire = s_axi_arready && s_axi_arvalid;

  always_comb begin
    status_word     = 32'(led_o);
    status_word[16] = phase;
`ifdef LED_CTRL_PWM_EN
    status_word[24] = pwm_gate;
`endif
  end

  always_comb begin
    rd_value = 32'd0;
    rd_err   = 1'b0;
    case (rd_idx)
      3'd0: rd_value = 32'(led_data);
      3'd1: rd_value = {31'd0, mode};
      3'd2: rd_value = period;
      3'd3: rd_value = status_word;
`ifdef LED_CTRL_PWM_EN
      3'd4: rd_value = {24'd0, duty};
`endif
      default: rd_err = 1'b1;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      s_axi_rdata <= 32'd0;
      s_axi_rresp <= RESP_OKAY;
    end else if (rd_fire) begin
      s_axi_rdata <= rd_value;
      s_axi_rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

endmodule

// File: tb/tb_axi_lite_led_ctrl.sv
// Self-checking bench for axi_lite_led_ctrl: directed register/blink checks plus random AXI traffic
// compared every cycle against a register-level model of the controller.
module tb_axi_lite_led_ctrl;

  localparam int          NL        = 4;
  localparam logic [31:0] RP        = 32'd25000000;
  localparam logic [31:0] LED_MASK  = (NL == 32) ? 32'hFFFF_FFFF : ((32'd1 << NL) - 32'd1);

  logic          tb_ACLK   = 1'b0;
  logic          tb_ARESET = 1'b1;
  logic [4:0]    awaddr    = '0;
  logic          awvalid   = 1'b0;
  logic          awready;
  logic [31:0]   wdata     = '0;
  logic [3:0]    wstrb     = '0;
  logic          wvalid    = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready    = 1'b1;
  logic [4:0]    araddr    = '0;
  logic          arvalid   = 1'b0;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready    = 1'b1;
  logic [NL-1:0] led_o;

  int total = 0;
  int bad   = 0;
  bit started  = 1'b0;
  bit rand_rdy = 1'b0;

  always #5 tb_ACLK = ~tb_ACLK;

  axi_lite_led_ctrl #(.C_ADDR_WIDTH(5), .NUM_LEDS(NL), .RESET_PERIOD(RP)) dut (
    .ACLK(tb_ACLK), .ARESET(tb_ARESET),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .led_o(led_o)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_led_data = '0, m_period = RP, m_led_o = '0, m_rdata = '0;
  logic        m_mode = 1'b0, m_wbusy = 1'b0, m_rvalid = 1'b0;
  logic [1:0]  m_bresp = 2'b00, m_rresp = 2'b00;
  longint      m_elapsed = 0;
  int          m_pwm = 0, m_duty = 255;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] strb);
    logic [31:0] r = old_v;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  // Phase is on during even-numbered half-periods of the cycles spent blinking since the last restart.
  function automatic bit phase_of(input longint e, input logic [31:0] p);
    if (p == 32'd0) return 1'b1;
    return ((e / longint'(p)) % 2) == 0;
  endfunction

  always @(posedge tb_ACLK) begin
    logic [31:0] p_led, p_period, p_ledo, stat;
    logic        p_mode, p_phase, gate, clr;
    int          p_duty, p_pwm;
    if (tb_ARESET) begin
      m_led_data = '0; m_mode = 1'b0; m_period = RP; m_elapsed = 0; m_led_o = '0;
      m_wbusy = 1'b0; m_rvalid = 1'b0; m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0;
      m_pwm = 0; m_duty = 255;
    end else begin
      p_led = m_led_data; p_mode = m_mode; p_period = m_period; p_ledo = m_led_o;
      p_phase = phase_of(m_elapsed, m_period); p_duty = m_duty; p_pwm = m_pwm;
`ifdef LED_CTRL_PWM_EN
      gate = (p_pwm < p_duty);
`else
      gate = 1'b1;
`endif
      m_led_o = ((p_mode && !p_phase) ? 32'd0 : p_led) & (gate ? LED_MASK : 32'd0);
      m_pwm   = (m_pwm + 1) % 256;

      if (!m_rvalid && arvalid) begin
        m_rvalid = 1'b1; m_rresp = 2'b00;
        stat = p_ledo | (32'(p_phase) << 16);
`ifdef LED_CTRL_PWM_EN
        stat = stat | (32'(gate) << 24);
`endif
        case (araddr[4:2])
          3'd0: m_rdata = p_led;
          3'd1: m_rdata = 32'(p_mode);
          3'd2: m_rdata = p_period;
          3'd3: m_rdata = stat;
`ifdef LED_CTRL_PWM_EN
          3'd4: m_rdata = 32'(p_duty);
`endif
          default: begin m_rdata = 32'd0; m_rresp = 2'b10; end
        endcase
      end else if (m_rvalid && rready) begin
        m_rvalid = 1'b0;
      end

      clr = 1'b0;
      if (!m_wbusy && awvalid && wvalid) begin
        m_wbusy = 1'b1; m_bresp = 2'b00;
        case (awaddr[4:2])
          3'd0: m_led_data = merge_bytes(p_led, wdata, wstrb) & LED_MASK;
          3'd1: begin if (wstrb[0]) m_mode = wdata[0]; clr = |wstrb; end
          3'd2: begin m_period = merge_bytes(p_period, wdata, wstrb); clr = |wstrb; end
`ifdef LED_CTRL_PWM_EN
          3'd4: if (wstrb[0]) m_duty = int'(wdata[7:0]);
`endif
          default: m_bresp = 2'b10;
        endcase
      end else if (m_wbusy && bready) begin
        m_wbusy = 1'b0;
      end

      if (clr || p_period == 32'd0) m_elapsed = 0;
      else if (p_mode)              m_elapsed = m_elapsed + 1;
    end
    started = 1'b1;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge tb_ACLK) begin
    if (started) begin
      check("awready", awready, !tb_ARESET && !m_wbusy && awvalid && wvalid);
      check("wready",  wready,  !tb_ARESET && !m_wbusy && awvalid && wvalid);
      check("arready", arready, !tb_ARESET && !m_rvalid);
      check("bvalid",  bvalid,  m_wbusy);
      if (m_wbusy) check("bresp", bresp, m_bresp);
      check("rvalid",  rvalid,  m_rvalid);
      if (m_rvalid) begin
        check("rdata", rdata, m_rdata);
        check("rresp", rresp, m_rresp);
      end
      check("led_o", led_o, m_led_o);
    end
  end

  // Randomised response back-pressure while enabled.
  initial forever begin
    @(posedge tb_ACLK); #1;
    if (rand_rdy) begin
      bready = 1'($urandom_range(0, 1));
      rready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- bus tasks ----------------
  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    bit ok = 1'b0;
    resp = 2'bxx;
    @(posedge tb_ACLK); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge tb_ACLK);
      if (awready) begin ok = 1'b1; break; end
    end
    check("aw_handshake", 32'(ok), 32'd1);
    @(posedge tb_ACLK); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge tb_ACLK);
      if (bvalid) begin ok = 1'b1; resp = bresp; break; end
    end
    check("b_arrives", 32'(ok), 32'd1);
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit ok = 1'b0;
    d = 'x; resp = 2'bxx;
    @(posedge tb_ACLK); #1;
    araddr = a; arvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge tb_ACLK);
      if (arready) begin ok = 1'b1; break; end
    end
    check("ar_handshake", 32'(ok), 32'd1);
    @(posedge tb_ACLK); #1;
    arvalid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge tb_ACLK);
      if (rvalid) begin ok = 1'b1; d = rdata; resp = rresp; break; end
    end
    check("r_arrives", 32'(ok), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    repeat (3) @(posedge tb_ACLK);
    #1 tb_ARESET = 1'b0;

    axi_read(5'h00, d, r); check("rst_led_data", d, 32'h0);        check("rst_rresp0", 32'(r), 0);
    axi_read(5'h04, d, r); check("rst_mode", d, 32'h0);            check("rst_rresp1", 32'(r), 0);
    axi_read(5'h08, d, r); check("rst_period", d, 32'h017D7840);   check("rst_rresp2", 32'(r), 0);
    axi_read(5'h0C, d, r);
`ifdef LED_CTRL_PWM_EN
    check("rst_status", d, 32'h0101_0000);
`else
    check("rst_status", d, 32'h0001_0000);
`endif
    check("rst_rresp3", 32'(r), 0);
    check("rst_led_o", 32'(led_o), 32'h0);

    bready = 1'b0;
    axi_write(5'h00, 32'hFFFF_FFFF, 4'hF, r);
    check("wr_led_bresp", 32'(r), 0);
    repeat (2) begin @(negedge tb_ACLK); check("bvalid_hold", 32'(bvalid), 1); end
    check("led_direct_F", 32'(led_o), 32'hF);
    @(posedge tb_ACLK); #1 bready = 1'b1;
    axi_read(5'h00, d, r); check("rb_led_data", d, 32'h0000_000F);

    axi_write(5'h00, 32'h5, 4'hF, r);
    axi_write(5'h08, 32'h4, 4'hF, r);
    axi_write(5'h04, 32'h1, 4'hF, r);
    for (int k = 1; k <= 16; k++) begin
      @(negedge tb_ACLK);
      check("blink_pattern", 32'(led_o), (((k - 1) / 4) % 2 == 0) ? 32'h5 : 32'h0);
    end

    axi_write(5'h08, 32'h0, 4'hF, r);
    for (int k = 0; k < 8; k++) begin
      @(negedge tb_ACLK);
      check("steady_on", 32'(led_o), 32'h5);
    end
    axi_read(5'h0C, d, r); check("status_steady", d & 32'h00FF_FFFF, 32'h0001_0005);

    axi_write(5'h0C, 32'hFFFF_FFFF, 4'hF, r); check("wr_status_slverr", 32'(r), 32'h2);
    axi_write(5'h14, 32'hFFFF_FFFF, 4'hF, r); check("wr_undec_slverr", 32'(r), 32'h2);
    axi_read(5'h18, d, r); check("rd_undec_data", d, 32'h0); check("rd_undec_rresp", 32'(r), 32'h2);
    axi_read(5'h00, d, r); check("keep_led_data", d, 32'h5);
    axi_read(5'h04, d, r); check("keep_mode", d, 32'h1);
    axi_read(5'h08, d, r); check("keep_period", d, 32'h0);

`ifdef LED_CTRL_PWM_EN
    begin
      int on_cnt = 0;
      axi_write(5'h04, 32'h0, 4'hF, r);
      axi_write(5'h00, 32'hF, 4'hF, r);
      axi_write(5'h10, 32'h40, 4'hF, r);
      repeat (2) @(negedge tb_ACLK);
      for (int k = 0; k < 256; k++) begin
        @(negedge tb_ACLK);
        if (led_o == 4'hF) on_cnt++;
      end
      check("pwm_on_cycles", 32'(on_cnt), 32'd64);
    end
`else
    axi_write(5'h10, 32'h40, 4'hF, r); check("wr_duty_slverr", 32'(r), 32'h2);
    axi_read(5'h10, d, r); check("rd_duty_data", d, 32'h0); check("rd_duty_rresp", 32'(r), 32'h2);
`endif

    rand_rdy = 1'b1;
    fork
      begin
        logic [1:0] wr_r;
        for (int n = 0; n < 80; n++) begin
          int unsigned idx = $urandom_range(0, 7);
          logic [31:0] wd = (idx == 2) ? 32'($urandom_range(0, 6)) : 32'($urandom);
          logic [3:0]  ws = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
          axi_write(5'(idx * 4), wd, ws, wr_r);
          repeat ($urandom_range(0, 6)) @(posedge tb_ACLK);
        end
      end
      begin
        logic [31:0] rd_d;
        logic [1:0]  rd_r;
        for (int n = 0; n < 80; n++) begin
          axi_read(5'($urandom_range(0, 7) * 4), rd_d, rd_r);
          repeat ($urandom_range(0, 4)) @(posedge tb_ACLK);
        end
      end
    join
    @(posedge tb_ACLK); #1;
    rand_rdy = 1'b0; bready = 1'b1; rready = 1'b1;
    repeat (20) @(posedge tb_ACLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
